// File: rtl/param_iqueue_if.sv
// Decode/issue handshake bundle for param_iqueue.
// The queue takes the slave modport; the producer/consumer side takes master.
interface param_iqueue_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             flush;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic             stalled;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             full;
  logic             almost_full;
  logic [CW-1:0]    count;

  modport master (
    output flush, load, data_in, stalled,
    input  data_out, data_valid, full, almost_full, count
  );

  modport slave (
    input  flush, load, data_in, stalled,
    output data_out, data_valid, full, almost_full, count
  );
endinterface

// File: rtl/param_iqueue.sv
// Parametrised in-order instruction queue (circular buffer) between decode and issue.
// Define IQUEUE_BYPASS_EN to let an empty queue hand data_in straight to issue.
module param_iqueue #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input logic           clk,
  input logic           reset_n,
  param_iqueue_if.slave q
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic             queued;
  logic             full_q;
  logic             pop;
  logic             push_ok;
  logic             wr_en;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign queued  = (count_q != '0);
  assign full_q  = (count_q == CW'(DEPTH));
  assign pop     = queued && !q.stalled;
  assign push_ok = q.load && (!full_q || pop);

`ifdef IQUEUE_BYPASS_EN
  logic bypass;

  // An unstalled bypass is consumed on the spot; a stalled one is stored as a normal push.
  assign bypass       = !queued && q.load && !q.flush && reset_n;
  assign wr_en        = push_ok && !(bypass && !q.stalled);
  assign q.data_valid = queued || bypass;
  assign q.data_out   = bypass ? q.data_in : mem[head_q];
`else
  assign wr_en        = push_ok;
  assign q.data_valid = queued;
  assign q.data_out   = mem[head_q];
`endif

  assign q.count       = count_q;
  assign q.full        = full_q;
  assign q.almost_full = (count_q >= CW'(AF_LEVEL));

  always_comb begin
    count_nxt = count_q;
    if (wr_en && !pop) begin
      count_nxt = count_q + CW'(1);
    end else if (!wr_en && pop) begin
      count_nxt = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (q.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      if (wr_en) begin
        tail_q <= ptr_inc(tail_q);
      end
      count_q <= count_nxt;
    end
  end

  // Flush only rewinds the pointers; stored entries are left in place.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && !q.flush) begin
      mem[tail_q] <= q.data_in;
    end
  end
endmodule
